// File: rtl/cpu_sequencer_pkg.sv
// cpu_sequencer_pkg: shared register/opcode types and instruction decode for the 4-bit CPU
package cpu_sequencer_pkg;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic       carry;
        logic [3:0] ip;
        logic [3:0] out;
    } regs_t;

    typedef enum logic [3:0] {
        NOP,
        ADD_A_IMM,
        MOV_A_B,
        IN_A,
        MOV_A_IMM,
        MOV_B_A,
        ADD_B_IMM,
        IN_B,
        MOV_B_IMM,
        OUT_B,
        OUT_IMM,
        JNC_IMM,
        JMP_IMM
    } opecode_t;

    // op field to operation; unused encodings fall back to NOP
    function automatic opecode_t decode_instr(logic [3:0] op);
        case (op)
            4'b0000: return ADD_A_IMM;
            4'b0001: return MOV_A_B;
            4'b0010: return IN_A;
            4'b0011: return MOV_A_IMM;
            4'b0100: return MOV_B_A;
            4'b0101: return ADD_B_IMM;
            4'b0110: return IN_B;
            4'b0111: return MOV_B_IMM;
            4'b1001: return OUT_B;
            4'b1011: return OUT_IMM;
            4'b1110: return JNC_IMM;
            4'b1111: return JMP_IMM;
            default: return NOP;
        endcase
    endfunction

endpackage

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/wait/exec sequencer that feeds the ALU and commits its result once per instruction
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int ROM_LATENCY = 1,
    parameter int TICK_DIV    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       step,
    output logic [3:0] rom_addr,
    input  logic [7:0] rom_data,
    output opecode_t   opecode,
    output logic [3:0] imm,
    output regs_t      current,
    input  regs_t      next,
    output logic [3:0] out_port,
    output logic       busy,
    output logic       retire
);

    typedef enum logic [1:0] {IDLE, FETCH, WAIT, EXEC} state_t;

    localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TICK_DIV - 1);
    localparam logic [1:0]    WMAX = 2'(ROM_LATENCY - 1);

    state_t        state, state_n;
    logic [1:0]    wcnt;
    logic [TW-1:0] tick;
    logic          pending;
    logic          start;
    opecode_t      op_q;
    logic [3:0]    imm_q;

    // a run tick (fresh or held pending) starts in run mode; only a step does when halted
    assign start    = state == IDLE && (run ? (pending || tick == '0) : step);
    assign busy     = state != IDLE;
    assign opecode  = state == EXEC ? op_q : NOP;
    assign imm      = state == EXEC ? imm_q : 4'd0;
    assign out_port = current.out;

    // next-state: one fetch cycle, ROM_LATENCY wait cycles, one exec cycle
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start ? FETCH : IDLE;
            FETCH:   state_n = WAIT;
            WAIT:    state_n = wcnt == WMAX ? EXEC : WAIT;
            default: state_n = IDLE;
        endcase
    end

    // state, pacing, instruction latch and architectural commit
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wcnt     <= 2'd0;
            tick     <= '0;
            pending  <= 1'b0;
            rom_addr <= 4'd0;
            op_q     <= NOP;
            imm_q    <= 4'd0;
            current  <= '0;
            retire   <= 1'b0;
        end else begin
            state    <= state_n;
            wcnt     <= state == WAIT ? wcnt + 2'd1 : 2'd0;
            tick     <= !run || tick == TMAX ? '0 : tick + TW'(1);
            pending  <= run && state != IDLE && (pending || tick == '0);
            rom_addr <= start ? current.ip : rom_addr;
            if (state == WAIT && wcnt == WMAX) begin
                op_q  <= decode_instr(rom_data[7:4]);
                imm_q <= rom_data[3:0];
            end
            current  <= state == EXEC ? next : current;
            retire   <= state == EXEC;
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed checks of the sequencer against a behavioural ROM and ALU
module tb_cpu_sequencer;
    import cpu_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic       step = 1'b0;
    logic [3:0] rom_addr;
    logic [7:0] rom_data = 8'h00;
    opecode_t   opecode;
    logic [3:0] imm;
    regs_t      current;
    regs_t      next;
    logic [3:0] out_port;
    logic       busy;
    logic       retire;

    logic [7:0] rom [16];
    int n_chk = 0;
    int n_pass = 0;

    cpu_sequencer dut (
        .clk(clk), .rst(rst), .run(run), .step(step),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .opecode(opecode), .imm(imm), .current(current), .next(next),
        .out_port(out_port), .busy(busy), .retire(retire)
    );

    always #5 clk = ~clk;

    // synchronous single-cycle ROM
    always @(posedge clk) rom_data <= rom[rom_addr];

    // reference ALU; input port tied to 0
    function automatic regs_t alu(opecode_t o, logic [3:0] im, regs_t c);
        regs_t r;
        logic [4:0] s;
        r = c;
        r.ip = c.ip + 4'd1;
        r.carry = 1'b0;
        s = 5'd0;
        case (o)
            ADD_A_IMM: begin s = {1'b0, c.a} + {1'b0, im}; r.a = s[3:0]; r.carry = s[4]; end
            MOV_A_B:   r.a = c.b;
            IN_A:      r.a = 4'd0;
            MOV_A_IMM: r.a = im;
            MOV_B_A:   r.b = c.a;
            ADD_B_IMM: begin s = {1'b0, c.b} + {1'b0, im}; r.b = s[3:0]; r.carry = s[4]; end
            IN_B:      r.b = 4'd0;
            MOV_B_IMM: r.b = im;
            OUT_B:     r.out = c.b;
            OUT_IMM:   r.out = im;
            JNC_IMM:   r.ip = c.carry ? c.ip + 4'd1 : im;
            JMP_IMM:   r.ip = im;
            default:   ;
        endcase
        return r;
    endfunction

    always_comb next = alu(opecode, imm, current);

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tk();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        tk();
        tk();
        rst = 1'b0;
    endtask

    // pulse step and wait until the retire cycle
    task automatic do_step();
        step = 1'b1;
        tk();
        step = 1'b0;
        repeat (3) tk();
    endtask

    initial begin
        int n;
        int k;
        int last;
        logic [3:0] exp_ip [3];
        exp_ip[0] = 4'd1;
        exp_ip[1] = 4'd2;
        exp_ip[2] = 4'd0;
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;

        // reset
        reset_dut();
        check("rst_regs", int'(current), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_op", int'(opecode), int'(NOP));
        check("rst_addr", int'(rom_addr), 0);
        check("rst_retire", int'(retire), 0);

        // single step, MOV A,3
        rom[0] = 8'h33;
        step = 1'b1;
        tk();
        step = 1'b0;
        check("step_busy", int'(busy), 1);
        tk();
        tk();
        check("step_exec_op", int'(opecode), int'(MOV_A_IMM));
        check("step_exec_imm", int'(imm), 3);
        check("step_no_early_retire", int'(retire), 0);
        tk();
        check("step_retire", int'(retire), 1);
        check("step_a", int'(current.a), 3);
        check("step_ip", int'(current.ip), 1);
        tk();
        check("step_retire_pulse", int'(retire), 0);
        check("step_idle", int'(busy), 0);

        // carry and JNC not taken
        reset_dut();
        rom[0] = 8'h3F;
        rom[1] = 8'h01;
        rom[2] = 8'hE5;
        do_step();
        check("c_a_f", int'(current.a), 15);
        do_step();
        check("c_a_wrap", int'(current.a), 0);
        check("c_carry", int'(current.carry), 1);
        tk();
        do_step();
        check("c_jnc_ip", int'(current.ip), 3);

        // free run with step held high
        reset_dut();
        rom[0] = 8'hB5;
        rom[1] = 8'h01;
        rom[2] = 8'hF0;
        run = 1'b1;
        step = 1'b1;
        k = 0;
        last = 0;
        for (int c = 0; c < 24; c++) begin
            tk();
            if (retire) begin
                check("run_ip", int'(current.ip), int'(exp_ip[k % 3]));
                if (k > 0) check("run_period", c - last, 4);
                last = c;
                k++;
            end
        end
        check("run_count", k, 6);
        check("run_out", int'(out_port), 5);
        run = 1'b0;
        step = 1'b0;
        n = 0;
        repeat (8) begin
            tk();
            n += int'(retire);
        end
        check("halt_no_retire", n, 0);

        // step while busy ignored
        n = 0;
        step = 1'b1;
        tk();
        step = 1'b0;
        tk();
        step = 1'b1;
        tk();
        step = 1'b0;
        repeat (8) begin
            tk();
            n += int'(retire);
        end
        check("busy_step_count", n, 1);
        check("busy_step_ip", int'(current.ip), 1);

        // reset during WAIT abandons the instruction
        reset_dut();
        rom[0] = 8'h37;
        step = 1'b1;
        tk();
        step = 1'b0;
        tk();
        rst = 1'b1;
        tk();
        rst = 1'b0;
        check("rstw_busy", int'(busy), 0);
        n = 0;
        repeat (5) begin
            tk();
            n += int'(retire);
        end
        check("rstw_no_retire", n, 0);
        check("rstw_a", int'(current.a), 0);

        // undefined op decodes to NOP and still advances ip
        rom[0] = 8'h80;
        step = 1'b1;
        tk();
        step = 1'b0;
        tk();
        tk();
        check("nop_op", int'(opecode), int'(NOP));
        tk();
        check("nop_ip", int'(current.ip), 1);
        check("nop_a", int'(current.a), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
